card_shoe: RTL and testbench

Shuffled 52-card source that feeds the blackjack game controller. It holds a full deck as an in-place permutation and shuffles it with a Fisher-Yates pass driven by a free-running LFSR. It then deals one card per draw request, in order, and reshuffles at a round boundary once the shoe runs low, or immediately if the shoe is emptied.

---
 rtl/card_shoe.sv | 158 +++++++++++++++
 tb/tb_card_shoe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// Shuffled 52-card shoe: Fisher-Yates shuffle driven by a free-running
// Galois LFSR, then in-order dealing with low-shoe and empty-shoe reshuffles.
module card_shoe #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned RESHUFFLE_AT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_draw,
  input  logic       i_newRound,
  output logic       o_cardValid,
  output logic [3:0] o_cardRank,
  output logic [1:0] o_cardSuit,
  output logic       o_ready,
  output logic [5:0] o_cardsLeft
);

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned ID_W      = 6;
  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [ID_W-1:0]   TOP_IDX  = 6'(DECK_SIZE - 1);
  localparam logic [ID_W-1:0]   FULL     = 6'(DECK_SIZE);

  typedef enum logic {
    SHUFFLE,
    READY
  } state_t;

  state_t state, state_next;

  logic [LFSR_W-1:0] lfsr;
  logic [ID_W-1:0]   deck [DECK_SIZE];
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   ptr;
  logic              pending;

  logic [ID_W-1:0]   j_c;
  logic              accept_c;
  logic              last_swap_c;
  logic              serve_c;
  logic              deal_c;
  logic              set_pending_c;
  logic [ID_W-1:0]   card_c;
  logic [ID_W-1:0]   rem_c;
  logic [3:0]        rank_c;
  logic [1:0]        suit_c;

  // Smallest 2^k-1 covering i, so j is uniform over [0, mask] before rejection.
  function automatic logic [ID_W-1:0] mask_of(input logic [ID_W-1:0] i);
    if (i > 6'd31)      return 6'd63;
    else if (i > 6'd15) return 6'd31;
    else if (i > 6'd7)  return 6'd15;
    else if (i > 6'd3)  return 6'd7;
    else if (i > 6'd1)  return 6'd3;
    else                return 6'd1;
  endfunction

  // Card ID decode: suit = id/13, rank = id%13 + 1 via compare/subtract.
  always_comb begin
    card_c = deck[ptr];
    suit_c = 2'd0;
    rem_c  = card_c;
    if (card_c >= 6'd39) begin
      suit_c = 2'd3;
      rem_c  = card_c - 6'd39;
    end else if (card_c >= 6'd26) begin
      suit_c = 2'd2;
      rem_c  = card_c - 6'd26;
    end else if (card_c >= 6'd13) begin
      suit_c = 2'd1;
      rem_c  = card_c - 6'd13;
    end
    rank_c = 4'(rem_c) + 4'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= SHUFFLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next    = state;
    j_c           = lfsr[ID_W-1:0] & mask_of(idx);
    accept_c      = 1'b0;
    last_swap_c   = 1'b0;
    serve_c       = 1'b0;
    deal_c        = 1'b0;
    set_pending_c = 1'b0;
    case (state)
      SHUFFLE: begin
        set_pending_c = i_draw;
        accept_c      = (j_c <= idx);
        if (accept_c && idx == 6'd1) begin
          last_swap_c = 1'b1;
          state_next  = READY;
        end
      end
      READY: begin
        // A pending request from the shuffle is served as if drawn now.
        serve_c = i_draw | pending;
        if (serve_c && o_cardsLeft != 6'd0) begin
          deal_c = 1'b1;
        end else if (serve_c) begin
          set_pending_c = 1'b1;
          state_next    = SHUFFLE;
        end else if (i_newRound && o_cardsLeft < 6'(RESHUFFLE_AT)) begin
          state_next = SHUFFLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lfsr        <= SEED_EFF;
      idx         <= TOP_IDX;
      ptr         <= '0;
      pending     <= 1'b0;
      o_cardValid <= 1'b0;
      o_cardRank  <= '0;
      o_cardSuit  <= '0;
      o_ready     <= 1'b0;
      o_cardsLeft <= '0;
      for (int unsigned k = 0; k < DECK_SIZE; k++) deck[k] <= 6'(k);
    end else begin
      lfsr        <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
      o_cardValid <= deal_c;
      o_ready     <= (state_next == READY);

      if (set_pending_c)  pending <= 1'b1;
      else if (deal_c)    pending <= 1'b0;

      // In-place swap of deck[idx] and deck[j]; j == idx degenerates to a hold.
      if (accept_c) begin
        for (int unsigned k = 0; k < DECK_SIZE; k++) begin
          if (6'(k) == idx)      deck[k] <= deck[j_c];
          else if (6'(k) == j_c) deck[k] <= deck[idx];
        end
        idx <= last_swap_c ? TOP_IDX : idx - 6'd1;
      end

      if (last_swap_c) begin
        ptr         <= '0;
        o_cardsLeft <= FULL;
      end

      if (deal_c) begin
        o_cardRank  <= rank_c;
        o_cardSuit  <= suit_c;
        ptr         <= ptr + 6'd1;
        o_cardsLeft <= o_cardsLeft - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Randomized bench for card_shoe against a deck-level reference model.
module tb_card_shoe;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int RESHUFFLE_AT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       draw = 1'b0;
  logic       new_round = 1'b0;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic       ready;
  logic [5:0] cards_left;

  card_shoe #(.SEED(SEED), .RESHUFFLE_AT(RESHUFFLE_AT)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_draw     (draw),
    .i_newRound (new_round),
    .o_cardValid(card_valid),
    .o_cardRank (card_rank),
    .o_cardSuit (card_suit),
    .o_ready    (ready),
    .o_cardsLeft(cards_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: deck as an array, shuffle computed whole at its start.
  int          m_deck [52];
  bit          m_ready;
  bit          m_pending;
  bit          m_valid;
  int          m_left, m_ptr, m_rem, m_rank, m_suit;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic start_shuffle(input logic [15:0] l0);
    int i, m, j, t, n;
    logic [15:0] l;
    i = 51; l = l0; n = 0;
    while (i >= 1) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      j = int'(l[5:0]) & m;
      if (j <= i) begin
        t = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = t;
        i--;
      end
      l = lfsr_step(l);
      n++;
    end
    m_rem   = n;
    m_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 52; k++) m_deck[k] = k;
    m_lfsr = SEED; m_pending = 0; m_valid = 0;
    m_left = 0; m_ptr = 0; m_rank = 0; m_suit = 0;
    start_shuffle(m_lfsr);
  endtask

  task automatic model_step(input bit d, input bit nr);
    bit serve;
    int id;
    m_valid = 0;
    if (!m_ready) begin
      if (d) m_pending = 1;
      m_rem--;
      if (m_rem == 0) begin
        m_ready = 1; m_left = 52; m_ptr = 0;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end else begin
      serve  = d | m_pending;
      m_lfsr = lfsr_step(m_lfsr);
      if (serve && m_left > 0) begin
        id = m_deck[m_ptr];
        m_suit = id / 13; m_rank = id % 13 + 1;
        m_ptr++; m_left--; m_valid = 1; m_pending = 0;
      end else if (serve) begin
        m_pending = 1;
        start_shuffle(m_lfsr);
      end else if (nr && m_left < RESHUFFLE_AT) begin
        start_shuffle(m_lfsr);
      end
    end
  endtask

  task automatic compare();
    check("ready", int'(ready), int'(m_ready));
    check("cards_left", int'(cards_left), m_left);
    check("card_valid", int'(card_valid), int'(m_valid));
    check("card_rank", int'(card_rank), m_rank);
    check("card_suit", int'(card_suit), m_suit);
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input bit d, input bit nr);
    draw = d; new_round = nr;
    @(posedge clk);
    model_step(d, nr);
    @(negedge clk);
    draw = 0; new_round = 0;
    compare();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_valid"}, int'(card_valid), 0);
    check({tag, "_rank"}, int'(card_rank), 0);
    check({tag, "_suit"}, int'(card_suit), 0);
    check({tag, "_left"}, int'(cards_left), 0);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready(input int budget, input bit rnd, output int cycles);
    cycles = 0;
    while (!ready && cycles < budget) begin
      cycle(rnd ? ($urandom_range(3) == 0) : 1'b0, $urandom_range(1) == 1);
      cycles++;
    end
    check("ready_timeout", int'(ready), 1);
  endtask

  task automatic draw_n(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0);
  endtask

  initial begin
    int lat, uniq;
    bit seen [52];

    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    wait_ready(300, 1'b0, lat);
    check("shuffle_latency_in_range", int'(lat >= 51 && lat <= 200), 1);
    check("full_after_shuffle", int'(cards_left), 52);

    // Full deal: every rank/suit exactly once.
    for (int k = 0; k < 52; k++) seen[k] = 0;
    uniq = 0;
    for (int k = 0; k < 52; k++) begin
      cycle(1'b1, 1'b0);
      if (card_valid && card_rank >= 1 && card_rank <= 13) begin
        if (!seen[int'(card_suit) * 13 + int'(card_rank) - 1]) uniq++;
        seen[int'(card_suit) * 13 + int'(card_rank) - 1] = 1;
      end
    end
    check("unique_cards", uniq, 52);
    check("empty_after_deal", int'(cards_left), 0);

    // Empty-shoe draw: reshuffle, then one pending card.
    cycle(1'b1, 1'b0);
    check("empty_draw_drops_ready", int'(ready), 0);
    wait_ready(300, 1'b1, lat);
    cycle(1'b0, 1'b0);
    check("pending_served", int'(card_valid), 1);
    check("left_after_pending", int'(cards_left), 51);
    cycle(1'b0, 1'b0);

    draw_n(39);
    cycle(1'b0, 1'b1);
    check("nr_at_12_reshuffles", int'(ready), 0);
    wait_ready(300, 1'b0, lat);

    draw_n(38);
    cycle(1'b0, 1'b1);
    check("nr_at_14_reshuffles", int'(ready), 0);
    wait_ready(300, 1'b0, lat);

    draw_n(37);
    cycle(1'b0, 1'b1);
    check("nr_at_15_ignored", int'(ready), 1);

    draw_n(5);
    cycle(1'b1, 1'b1);
    check("draw_nr_same_cycle_valid", int'(card_valid), 1);
    check("draw_nr_same_cycle_left", int'(cards_left), 9);
    check("draw_nr_same_cycle_ready", int'(ready), 1);

    for (int k = 0; k < 400; k++)
      cycle($urandom_range(9) < 6, $urandom_range(9) == 0);

    // Reset mid-shuffle, then mid-deal; both must replay the first deck order.
    do_reset("rst_a");
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0);
    do_reset("rst_mid_shuffle");
    wait_ready(300, 1'b0, lat);
    draw_n(52);
    cycle(1'b1, 1'b0);
    wait_ready(300, 1'b0, lat);
    draw_n(20);
    do_reset("rst_mid_deal");
    wait_ready(300, 1'b0, lat);
    draw_n(30);
    for (int k = 0; k < 200; k++)
      cycle($urandom_range(9) < 7, $urandom_range(4) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=1 exp=0");
    $fatal(1, "watchdog");
  end

endmodule
